// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, RAM lane codes, default widths.
package loader_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] LANE_OPC = 2'd0;
    localparam logic [1:0] LANE_OP1 = 2'd1;
    localparam logic [1:0] LANE_OP2 = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        OP0,
        OP1,
        OP2,
        CHK,
        DONE,
        ERROR
    } state_t;

    function automatic logic [1:0] lane_of(state_t s);
        case (s)
            OP1:     return LANE_OP1;
            OP2:     return LANE_OP2;
            default: return LANE_OPC;
        endcase
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM write port of the program loader.
// master = byte source / RAM side, slave = loader.
interface program_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [DATA_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [1:0]        ram_lane;
    logic              ram_we;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  ram_data,
        input  ram_addr,
        input  ram_lane,
        input  ram_we
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output ram_data,
        output ram_addr,
        output ram_lane,
        output ram_we
    );

endinterface

// File: rtl/program_loader.sv
// Purpose: loads header N + 3*N opcode/operand bytes into program RAM, holds CPU in reset until done (LOADER_CHECKSUM_EN adds an XOR check byte).
// Latency: RAM write strobe exactly 1 cycle after each data-byte accept; 1 byte/cycle sustained.
// Backpressure: byte_ready only in receiving states; the RAM never stalls.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_WORDS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    program_loader_if.slave  bus,
    output logic             cpu_rst_hold,
    output logic             busy,
    output logic             done,
    output logic             error
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic [DATA_W-1:0] n_words;
    logic              accept;
    logic              is_op;
    logic              start_ok;
    logic              hdr_bad;
    logic              last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign is_op     = (state == OP0) || (state == OP1) || (state == OP2);
    assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign hdr_bad   = (bus.byte_in == '0) || (int'(bus.byte_in) > MAX_WORDS);
    assign cnt_inc   = cnt + 1'b1;
    assign last_word = (int'(cnt_inc) == int'(n_words));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = HEADER;
            HEADER:            if (accept) state_nxt = hdr_bad ? ERROR : OP0;
            OP0:               if (accept) state_nxt = OP1;
            OP1:               if (accept) state_nxt = OP2;
            OP2: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = last_word ? CHK : OP0;
`else
                    state_nxt = last_word ? DONE : OP0;
`endif
                end
            end
            CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) state_nxt = (bus.byte_in == csum) ? DONE : ERROR;
`else
                state_nxt = ERROR;
`endif
            end
            default:           state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.byte_ready <= 1'b0;
            bus.ram_data   <= '0;
            bus.ram_addr   <= '0;
            bus.ram_lane   <= LANE_OPC;
            bus.ram_we     <= 1'b0;
            cpu_rst_hold   <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            cnt            <= '0;
            n_words        <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            state          <= state_nxt;
            bus.byte_ready <= (state_nxt == HEADER) || (state_nxt == OP0) || (state_nxt == OP1)
                              || (state_nxt == OP2) || (state_nxt == CHK);
            busy           <= (state_nxt == HEADER) || (state_nxt == OP0) || (state_nxt == OP1)
                              || (state_nxt == OP2) || (state_nxt == CHK);
            done           <= (state_nxt == DONE);
            error          <= (state_nxt == ERROR);
            cpu_rst_hold   <= (state_nxt != DONE);
            bus.ram_we     <= accept && is_op;

            if (accept && is_op) begin
                bus.ram_data <= bus.byte_in;
                bus.ram_addr <= cnt[ADDR_W-1:0];
                bus.ram_lane <= lane_of(state);
            end

            if (start_ok)
                cnt <= '0;
            else if (accept && (state == OP2))
                cnt <= cnt_inc;

            if (accept && (state == HEADER))
                n_words <= bus.byte_in;

`ifdef LOADER_CHECKSUM_EN
            // The header byte is part of the running XOR.
            if (start_ok)
                csum <= '0;
            else if (accept && (state != CHK))
                csum <= csum ^ bus.byte_in;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; follows LOADER_CHECKSUM_EN when defined.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_rst_hold;
    logic busy;
    logic done;
    logic error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] wr_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  stim [0:191];

    program_loader_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    program_loader #(.ADDR_W(6), .DATA_W(8), .MAX_WORDS(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_rst_hold (cpu_rst_hold),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // RAM write log: {addr[5:0], lane[1:0], data[7:0]}
    always @(posedge clk) begin
        #1;
        if (bus.ram_we === 1'b1)
            wr_q.push_back({bus.ram_addr, bus.ram_lane, bus.ram_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ram_data"},     32'(bus.ram_data), 32'h0);
        chk({tag, "_ram_addr"},     32'(bus.ram_addr), 32'h0);
        chk({tag, "_ram_lane"},     32'(bus.ram_lane), 32'h0);
        chk({tag, "_ram_we"},       32'(bus.ram_we), 32'h0);
        chk({tag, "_byte_ready"},   32'(bus.byte_ready), 32'h0);
        chk({tag, "_busy"},         32'(busy), 32'h0);
        chk({tag, "_done"},         32'(done), 32'h0);
        chk({tag, "_error"},        32'(error), 32'h0);
        chk({tag, "_cpu_rst_hold"}, 32'(cpu_rst_hold), 32'h1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit is_data, input bit gaps);
        int w;
        if (gaps) begin
            repeat ($urandom_range(2, 0)) begin
                bus.byte_valid = 1'b0;
                start = ($urandom_range(1, 0) == 1);
                @(negedge clk);
                start = 1'b0;
            end
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        w = 0;
        while (bus.byte_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("byte_ready", 32'(bus.byte_ready), 32'h1);
        if (bus.byte_ready !== 1'b1) begin
            bus.byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        chk("wr_latency_we", 32'(bus.ram_we), 32'(is_data));
        if (is_data) chk("wr_latency_data", 32'(bus.ram_data), 32'(b));
    endtask

    task automatic load(input int n, input bit gaps);
        logic [7:0] cs;
        cs = 8'(n);
        send_byte(8'(n), 1'b0, gaps);
        for (int i = 0; i < 3 * n; i++) begin
            send_byte(stim[i], 1'b1, gaps);
            exp_q.push_back({6'(i / 3), 2'(i % 3), stim[i]});
            cs = cs ^ stim[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs, 1'b0, gaps);
`endif
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk({tag, "_entry"}, 32'(wr_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_logs();
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic set_small_stream();
        stim[0] = 8'h01; stim[1] = 8'hAA; stim[2] = 8'hBB;
        stim[3] = 8'h02; stim[4] = 8'hCC; stim[5] = 8'hDD;
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(bus.byte_ready), 32'h0);

        // N=2 basic load
        set_small_stream();
        clear_logs();
        pulse_start();
        chk("start_busy", 32'(busy), 32'h1);
        chk("start_hold", 32'(cpu_rst_hold), 32'h1);
        load(2, 1'b0);
        chk("n2_done", 32'(done), 32'h1);
        chk("n2_hold", 32'(cpu_rst_hold), 32'h0);
        chk("n2_busy", 32'(busy), 32'h0);
        chk("n2_count", 32'(wr_q.size()), 32'd6);
        if (wr_q.size() == 6) begin
            chk("n2_w0", 32'(wr_q[0]), 32'h0001);
            chk("n2_w1", 32'(wr_q[1]), 32'h01AA);
            chk("n2_w2", 32'(wr_q[2]), 32'h02BB);
            chk("n2_w3", 32'(wr_q[3]), 32'h0402);
            chk("n2_w4", 32'(wr_q[4]), 32'h05CC);
            chk("n2_w5", 32'(wr_q[5]), 32'h06DD);
        end

        // Illegal headers: 0 and 65
        clear_logs();
        pulse_start();
        chk("reload_done_clr", 32'(done), 32'h0);
        send_byte(8'h00, 1'b0, 1'b0);
        chk("hdr0_error", 32'(error), 32'h1);
        chk("hdr0_hold", 32'(cpu_rst_hold), 32'h1);
        chk("hdr0_busy", 32'(busy), 32'h0);
        pulse_start();
        chk("restart_err_clr", 32'(error), 32'h0);
        send_byte(8'h41, 1'b0, 1'b0);
        chk("hdr65_error", 32'(error), 32'h1);
        chk("hdr65_hold", 32'(cpu_rst_hold), 32'h1);
        repeat (2) @(negedge clk);
        chk("hdr_no_writes", 32'(wr_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        clear_logs();
        pulse_start();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h10, 1'b1, 1'b0);
        send_byte(8'h20, 1'b1, 1'b0);
        send_byte(8'h30, 1'b1, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        chk("cs_good_done", 32'(done), 32'h1);
        chk("cs_good_err", 32'(error), 32'h0);
        chk("cs_good_writes", 32'(wr_q.size()), 32'd3);
        pulse_start();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h10, 1'b1, 1'b0);
        send_byte(8'h20, 1'b1, 1'b0);
        send_byte(8'h30, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        chk("cs_bad_error", 32'(error), 32'h1);
        chk("cs_bad_done", 32'(done), 32'h0);
        chk("cs_bad_hold", 32'(cpu_rst_hold), 32'h1);
`endif

        // N=64 at full rate
        for (int i = 0; i < 64; i++) begin
            stim[3*i]   = 8'(i);
            stim[3*i+1] = 8'(i + 8'h40);
            stim[3*i+2] = 8'(i + 8'h80);
        end
        clear_logs();
        pulse_start();
        load(64, 1'b0);
        chk("n64_done", 32'(done), 32'h1);
        repeat (4) @(negedge clk);
        chk("n64_count", 32'(wr_q.size()), 32'd192);
        if (wr_q.size() == 192) begin
            chk("n64_last", 32'(wr_q[191]), 32'hFEBF);
            chk("n64_w31", 32'(wr_q[31]), 32'h294A);
        end
        cmp_log("n64");

        // Reset after the 4th data byte
        set_small_stream();
        clear_logs();
        pulse_start();
        send_byte(8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(stim[i], 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
        stim[3] = 8'h44; stim[4] = 8'h55; stim[5] = 8'h66;
        pulse_start();
        load(2, 1'b0);
        chk("after_rst_done", 32'(done), 32'h1);
        cmp_log("after_rst");

        // Random gaps on byte_valid with stray start pulses while busy
        set_small_stream();
        clear_logs();
        pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ignored", 32'(busy), 32'h1);
        load(2, 1'b1);
        chk("gaps_done", 32'(done), 32'h1);
        repeat (3) @(negedge clk);
        cmp_log("gaps");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side counterpart of the CPU's instruction fetch path.
- Accepts a byte stream on a valid/ready handshake and deposits opcode/operand triplets into program RAM at word addresses 0..N-1.
- Holds the CPU in reset until the load completes.
- Sits between the external byte source and the RAM write port (data, lane, address, write enable).

Parameters:
- ADDR_W, 6, RAM word-address width; must match the PC width.
- DATA_W, 8, byte/lane width.
- MAX_WORDS, 64, maximum instruction count accepted (≤ 2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERROR.
- byte_in  in  DATA_W  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- ram_data  out  DATA_W  byte to write.
- ram_addr  out  ADDR_W  word address.
- ram_lane  out  2  byte lane: 0 = opcode, 1 = operand 1, 2 = operand 2.
- ram_we  out  1  one-cycle write strobe.
- cpu_rst_hold  out  1  high = keep CPU in reset.
- busy  out  1  load in progress.
- done  out  1  load completed successfully; sticky until next start or rst.
- error  out  1  load aborted; sticky until next start or rst.

Behaviour:
- Reset values: state = IDLE; ram_data = 0, ram_addr = 0, ram_lane = 0, ram_we = 0, byte_ready = 0, busy = 0, done = 0, error = 0; cpu_rst_hold = 1; word counter = 0; checksum = 0.
- Handshake: a byte is accepted when byte_valid && byte_ready on a rising edge.
  - byte_ready = 1 in HEADER, OP0, OP1, OP2 and CHK; 0 otherwise.
  - No backpressure from RAM: every write completes in one cycle.
- Stream format: header byte N (instruction count), then 3·N bytes ordered opcode, operand1, operand2 per word, then a checksum byte (feature-dependent; see Optional Feature).
- States and transitions:
  - IDLE: on start → HEADER; busy = 1; cpu_rst_hold = 1; done and error cleared; counter cleared.
  - HEADER: on accept, if N == 0 or N > MAX_WORDS → ERROR. Otherwise latch N → OP0.
  - OP0 / OP1 / OP2: on accept, register the write. ram_we pulses the cycle after the accept, with ram_addr = counter and ram_lane = 0 / 1 / 2 respectively. Transitions OP0→OP1→OP2.
  - After OP2 accept: counter increments (the write uses the pre-increment value). If counter+1 == N → CHK, else → OP0.
  - CHK: behaviour per Optional Feature.
  - DONE: done = 1, busy = 0, cpu_rst_hold = 0. start → HEADER (reload).
  - ERROR: error = 1, busy = 0, cpu_rst_hold = 1. start → HEADER.
- Write latency: exactly 1 cycle from byte accept to ram_we. ram_we is never high for 2 consecutive cycles unless bytes are accepted back-to-back. Back-to-back bytes are supported at full rate (1 byte/cycle).
- start asserted while busy: ignored.
- byte_valid outside receiving states: ignored, no accept.
- N == MAX_WORDS: legal. Last address = MAX_WORDS-1; the counter does not wrap into an extra write.
- rst mid-load: immediate return to reset values. Partially written RAM contents are not cleared; cpu_rst_hold = 1.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - Running XOR of all accepted bytes, including the header.
  - In CHK, the accepted byte is compared against the running XOR: equal → DONE, else → ERROR.
  - The checksum byte produces no RAM write.
- Disabled:
  - No CHK state.
  - After the final OP2 accept, the FSM goes directly to DONE. done rises in the same cycle as the last ram_we.

Decomposition:
- Package loader_pkg:
  - state enum (IDLE, HEADER, OP0, OP1, OP2, CHK, DONE, ERROR).
  - lane constants LANE_OPC = 0, LANE_OP1 = 1, LANE_OP2 = 2.
  - default ADDR_W / DATA_W.
- Single module; no sub-module needed. The write-register stage stays inline.

Test Plan:
- start; stream N=2, bytes 0x01 0xAA 0xBB 0x02 0xCC 0xDD → writes (addr0, lane0..2) = 01/AA/BB and (addr1, lane0..2) = 02/CC/DD, each 1 cycle after accept. done = 1, cpu_rst_hold = 0.
- Header 0x00, and separately header 0x41 (65) → error = 1, no ram_we, cpu_rst_hold stays 1.
- With LOADER_CHECKSUM_EN: N=1, 0x10 0x20 0x30, checksum 0x01^0x10^0x20^0x30 = 0x01 → done. Checksum 0x00 → error.
- N=64 at full rate with byte_valid held high → exactly 192 ram_we pulses, final ram_addr = 63, no write beyond. Then done.
- Assert rst after the 4th data byte → all outputs return to reset values next edge. A new start + full stream then loads correctly.
- Toggle byte_valid randomly (50%) during a load → identical RAM write sequence; start pulses during busy are ignored.
